// File: rtl/decoder_pkg.sv
// ----------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the decoder_scan slice.
//   MODE_DECODE / MODE_SCAN : values of the mode input and of the mode register
//   ONEHOT_MAX_W            : widest one-hot vector onehot() can build
//   clog2()                 : ceiling log2, minimum result 1
//   onehot()                : one-hot vector with bit idx set when idx < n
// ----------------------------------------------------------------------------
package decoder_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // 256 bits keeps the bit-select index at exactly 8 bits
    localparam int unsigned ONEHOT_MAX_W = 256;

    // Ceiling log2; never returns 0 so counters are at least one bit wide
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((w < 32) && ((32'd1 << w) < value)) begin
            w = w + 1;
        end
        return w;
    endfunction

    // One-hot vector; callers truncate to their own OUT_N width
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                        input int unsigned n);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if ((idx < n) && (idx < ONEHOT_MAX_W)) begin
            v[idx[7:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// ----------------------------------------------------------------------------
// scan_tick_gen
// SCAN_DIV clock divider for the scan stepper.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset, clears the divider
//   en    : count enable; 0 holds the divider
//   clear : synchronous clear, wins over en
//   tick  : high while the divider sits on its last count (SCAN_DIV-1)
// ----------------------------------------------------------------------------
module scan_tick_gen
    import decoder_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] r_div_cnt;
    logic             w_last;

    assign w_last = (r_div_cnt == CNT_LAST);

    // Divider: wraps to 0 on the last count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (clear) begin
            r_div_cnt <= '0;
        end else if (en) begin
            r_div_cnt <= w_last ? '0 : r_div_cnt + CNT_W'(1);
        end
    end

    assign tick = w_last;

endmodule

// File: rtl/decoder_scan.sv
// ----------------------------------------------------------------------------
// decoder_scan
// Binary-to-one-hot decoder with registered outputs and an auto-scan mode.
// DECODE latches in_sel on in_valid; SCAN steps the one-hot output through all
// OUT_N positions, SCAN_DIV cycles per position.
//   clk        : system clock, rising edge
//   reset      : synchronous active-high reset
//   en         : global enable, 0 freezes all state
//   mode       : 0 = DECODE, 1 = SCAN
//   in_valid   : DECODE strobe for in_sel
//   in_sel     : select value
//   out_onehot : registered one-hot, inverted when ACTIVE_LOW != 0
//   out_valid  : out_onehot holds a legal active pattern
//   scan_idx   : current scan position
//   step       : one-cycle pulse with each scan_idx advance
//   range_err  : one-cycle pulse when an out-of-range in_sel was accepted
// Optional build macro DECODER_SCAN_BLANK_EN: one inactive (blank) cycle after
// every scan step for anti-ghosting dead time.
// ----------------------------------------------------------------------------
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned OUT_N      = 8,
    parameter int unsigned SCAN_DIV   = 4,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] in_sel,
    output logic [OUT_N-1:0] out_onehot,
    output logic             out_valid,
    output logic [SEL_W-1:0] scan_idx,
    output logic             step,
    output logic             range_err
);

    localparam logic [OUT_N-1:0] POL      = {OUT_N{ACTIVE_LOW != 0}};
    localparam logic [OUT_N-1:0] INACTIVE = POL;
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_N - 1);
    // When OUT_N fills the whole select space every code is legal and
    // SEL_W'(OUT_N) would wrap to 0, so the range check is bypassed.
    localparam bit               ALL_LEGAL = (OUT_N >= (32'd1 << SEL_W));

    logic             r_mode_q;
    logic [SEL_W-1:0] r_scan_idx;
    logic [OUT_N-1:0] r_onehot;
    logic             r_out_valid;
    logic             r_step;
    logic             r_range_err;

    logic             w_mode_chg;
    logic             w_cnt_en;
    logic             w_clear;
    logic             w_tick;
    logic             w_sel_ok;
    logic [SEL_W-1:0] w_next_idx;
    logic [OUT_N-1:0] w_sel_pat;
    logic [OUT_N-1:0] w_next_pat;
    logic [OUT_N-1:0] w_zero_pat;

    assign w_mode_chg = (mode != r_mode_q);
    // Divider runs only while steadily in SCAN; a mode change restarts it
    assign w_cnt_en   = en && !w_mode_chg && (r_mode_q == MODE_SCAN);
    assign w_clear    = en && w_mode_chg;

    assign w_sel_ok   = ALL_LEGAL || (in_sel < SEL_W'(OUT_N));
    assign w_next_idx = (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + SEL_W'(1);

    // Output patterns with polarity already applied
    assign w_sel_pat  = OUT_N'(onehot(32'(in_sel), OUT_N)) ^ POL;
    assign w_next_pat = OUT_N'(onehot(32'(w_next_idx), OUT_N)) ^ POL;
    assign w_zero_pat = OUT_N'(onehot(32'd0, OUT_N)) ^ POL;

`ifdef DECODER_SCAN_BLANK_EN
    logic             r_blank;
    logic [OUT_N-1:0] w_cur_pat;

    assign w_cur_pat  = OUT_N'(onehot(32'(r_scan_idx), OUT_N)) ^ POL;
`endif

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (w_cnt_en),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // Mode, scan index, output and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q    <= MODE_DECODE;
            r_scan_idx  <= '0;
            r_onehot    <= INACTIVE;
            r_out_valid <= 1'b0;
            r_step      <= 1'b0;
            r_range_err <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            r_blank     <= 1'b0;
`endif
        end else if (!en) begin
            r_step      <= 1'b0;
            r_range_err <= 1'b0;
        end else if (w_mode_chg) begin
            r_mode_q    <= mode;
            r_scan_idx  <= '0;
            r_step      <= 1'b0;
            r_range_err <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
            r_blank     <= 1'b0;
`endif
            if (mode == MODE_SCAN) begin
                r_onehot    <= w_zero_pat;
                r_out_valid <= 1'b1;
            end else begin
                r_onehot    <= INACTIVE;
                r_out_valid <= 1'b0;
            end
        end else if (r_mode_q == MODE_SCAN) begin
            r_range_err <= 1'b0;
            r_step      <= w_tick;
            if (w_tick) begin
                r_scan_idx  <= w_next_idx;
`ifdef DECODER_SCAN_BLANK_EN
                r_onehot    <= INACTIVE;
                r_out_valid <= 1'b0;
                r_blank     <= 1'b1;
`else
                r_onehot    <= w_next_pat;
                r_out_valid <= 1'b1;
`endif
            end
`ifdef DECODER_SCAN_BLANK_EN
            else if (r_blank) begin
                r_onehot    <= w_cur_pat;
                r_out_valid <= 1'b1;
                r_blank     <= 1'b0;
            end
`endif
        end else begin
            r_step <= 1'b0;
            if (in_valid && w_sel_ok) begin
                r_onehot    <= w_sel_pat;
                r_out_valid <= 1'b1;
                r_range_err <= 1'b0;
            end else if (in_valid) begin
                r_onehot    <= INACTIVE;
                r_out_valid <= 1'b0;
                r_range_err <= 1'b1;
            end else begin
                r_range_err <= 1'b0;
            end
        end
    end

`ifndef DECODER_SCAN_BLANK_EN
    // Only the non-blanking build consumes the look-ahead pattern unconditionally
`endif

    assign out_onehot = r_onehot;
    assign out_valid  = r_out_valid;
    assign scan_idx   = r_scan_idx;
    assign step       = r_step;
    assign range_err  = r_range_err;

endmodule

// File: tb/tb_decoder_scan.sv
// ----------------------------------------------------------------------------
// tb_decoder_scan
// Directed bench for decoder_scan, SEL_W=3 OUT_N=6 SCAN_DIV=4. A second
// instance with ACTIVE_LOW=1 shares the stimulus and must show the inverted
// pattern. Expectations follow DECODER_SCAN_BLANK_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_decoder_scan;

`ifdef DECODER_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       mode;
    logic       in_valid;
    logic [2:0] in_sel;

    logic [5:0] oh;
    logic       valid;
    logic [2:0] idx;
    logic       stp;
    logic       rerr;

    logic [5:0] oh_al;
    logic       valid_al;
    logic [2:0] idx_al;
    logic       stp_al;
    logic       rerr_al;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(3), .OUT_N(6), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
        .in_sel(in_sel), .out_onehot(oh), .out_valid(valid), .scan_idx(idx),
        .step(stp), .range_err(rerr)
    );

    decoder_scan #(.SEL_W(3), .OUT_N(6), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .in_valid(in_valid),
        .in_sel(in_sel), .out_onehot(oh_al), .out_valid(valid_al), .scan_idx(idx_al),
        .step(stp_al), .range_err(rerr_al)
    );

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    // Reset state, including reset winning over live inputs
    task automatic test_reset();
        logic [11:0] got, exp;
        reset = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 3'd0;
        clk_step();
        in_valid = 1'b1; in_sel = 3'd5; mode = 1'b1;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000000, 1'b0, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL reset_state: got %b exp %b", got, exp); end
        checks++; got = {oh_al, valid_al, idx_al, stp_al, rerr_al}; exp = {6'b111111, 1'b0, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL reset_state_al: got %b exp %b", got, exp); end
        mode = 1'b0; in_valid = 1'b0; in_sel = 3'd0;
        reset = 1'b0;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000000, 1'b0, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL post_reset_idle: got %b exp %b", got, exp); end
    endtask

    // DECODE: one-cycle latency, hold after strobe drops, back-to-back selects
    task automatic test_decode();
        logic [7:0] got, exp;
        logic [2:0] sel_tab [3];
        logic [5:0] exp_tab [3];
        sel_tab = '{3'd0, 3'd3, 3'd1};
        exp_tab = '{6'b000001, 6'b001000, 6'b000010};
        in_valid = 1'b1; in_sel = 3'd5;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b100000, 1'b1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL decode_sel5: got %b exp %b", got, exp); end
        checks++;
        if (oh_al !== 6'b011111) begin errors++; $display("FAIL decode_sel5_al: got %b exp %b", oh_al, 6'b011111); end
        in_valid = 1'b0; in_sel = 3'd2;
        clk_step();
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b100000, 1'b1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL decode_hold: got %b exp %b", got, exp); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = sel_tab[i];
            clk_step();
            checks++; got = {oh, valid, rerr}; exp = {exp_tab[i], 1'b1, 1'b0};
            if (got !== exp) begin errors++; $display("FAIL decode_b2b_%0d: got %b exp %b", i, got, exp); end
        end
        checks++;
        if (idx !== 3'd0) begin errors++; $display("FAIL decode_idx_hold: got %0d exp 0", idx); end
        in_valid = 1'b0;
    endtask

    // Out-of-range selects, boundary OUT_N, en=0 ignoring the strobe
    task automatic test_range_err();
        logic [7:0] got, exp;
        in_valid = 1'b1; in_sel = 3'd7;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b000000, 1'b0, 1'b1};
        if (got !== exp) begin errors++; $display("FAIL range_sel7: got %b exp %b", got, exp); end
        in_valid = 1'b0;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b000000, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL range_pulse_end: got %b exp %b", got, exp); end
        in_valid = 1'b1; in_sel = 3'd6;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b000000, 1'b0, 1'b1};
        if (got !== exp) begin errors++; $display("FAIL range_sel6: got %b exp %b", got, exp); end
        in_sel = 3'd4;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b010000, 1'b1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL range_then_sel4: got %b exp %b", got, exp); end
        en = 1'b0; in_sel = 3'd7;
        clk_step();
        checks++; got = {oh, valid, rerr}; exp = {6'b010000, 1'b1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL en_off_ignores: got %b exp %b", got, exp); end
        en = 1'b1; in_valid = 1'b0;
    endtask

    // SCAN entry then 28 cycles: each position held 4 cycles, wrap 5 -> 0
    task automatic test_scan();
        logic [10:0] got, exp;
        logic [5:0]  eoh;
        logic [2:0]  eidx;
        logic        est;
        mode = 1'b1;
        clk_step();
        checks++; got = {oh, valid, idx, stp}; exp = {6'b000001, 1'b1, 3'd0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL scan_entry: got %b exp %b", got, exp); end
        for (int k = 1; k <= 28; k++) begin
            clk_step();
            eidx = 3'((k / 4) % 6);
            est  = ((k % 4) == 0);
            eoh  = (est && BLANK) ? 6'b000000 : (6'b000001 << eidx);
            checks++; got = {oh, valid, idx, stp}; exp = {eoh, !(est && BLANK), eidx, est};
            if (got !== exp) begin errors++; $display("FAIL scan_cycle_%0d: got %b exp %b", k, got, exp); end
            checks++;
            if (oh_al !== ~eoh) begin errors++; $display("FAIL scan_al_cycle_%0d: got %b exp %b", k, oh_al, ~eoh); end
        end
    endtask

    // en low for 3 cycles mid-position stretches it to 7 cycles
    task automatic test_en_freeze();
        logic [10:0] got, exp;
        clk_step();
        checks++; got = {oh, valid, idx, stp}; exp = {6'b000010, 1'b1, 3'd1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL freeze_pre: got %b exp %b", got, exp); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            checks++; got = {oh, valid, idx, stp}; exp = {6'b000010, 1'b1, 3'd1, 1'b0};
            if (got !== exp) begin errors++; $display("FAIL freeze_hold_%0d: got %b exp %b", i, got, exp); end
        end
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            checks++; got = {oh, valid, idx, stp}; exp = {6'b000010, 1'b1, 3'd1, 1'b0};
            if (got !== exp) begin errors++; $display("FAIL freeze_resume_%0d: got %b exp %b", i, got, exp); end
        end
        clk_step();
        checks++; got = {oh, valid, idx, stp};
        exp = {(BLANK ? 6'b000000 : 6'b000100), !BLANK, 3'd2, 1'b1};
        if (got !== exp) begin errors++; $display("FAIL freeze_step: got %b exp %b", got, exp); end
    endtask

    // Reset at scan_idx 3, then scan restarts from 0 with mode still high
    task automatic test_reset_mid_scan();
        logic [11:0] got, exp;
        for (int i = 0; i < 4; i++) clk_step();
        checks++;
        if ({idx, stp} !== {3'd3, 1'b1}) begin errors++; $display("FAIL reach_idx3: got %0d/%0d exp 3/1", idx, stp); end
        reset = 1'b1;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000000, 1'b0, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL reset_mid_scan: got %b exp %b", got, exp); end
        reset = 1'b0;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000001, 1'b1, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL scan_restart: got %b exp %b", got, exp); end
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if ({idx, stp} !== {3'd0, 1'b0}) begin errors++; $display("FAIL restart_no_step: got %0d/%0d exp 0/0", idx, stp); end
        clk_step();
        checks++;
        if ({idx, stp} !== {3'd1, 1'b1}) begin errors++; $display("FAIL restart_step: got %0d/%0d exp 1/1", idx, stp); end
    endtask

    // Mode change and en=0 on a step boundary; scan ignores in_valid
    task automatic test_boundary();
        logic [11:0] got, exp;
        in_valid = 1'b1; in_sel = 3'd7;
        for (int i = 0; i < 3; i++) clk_step();
        checks++;
        if (rerr !== 1'b0) begin errors++; $display("FAIL scan_no_range_err: got %b exp 0", rerr); end
        mode = 1'b0;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000000, 1'b0, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL mode_chg_at_boundary: got %b exp %b", got, exp); end
        mode = 1'b1;
        clk_step();
        for (int i = 0; i < 3; i++) clk_step();
        en = 1'b0;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000001, 1'b1, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL en_off_boundary: got %b exp %b", got, exp); end
        en = 1'b1;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr};
        exp = {(BLANK ? 6'b000000 : 6'b000010), !BLANK, 3'd1, 1'b1, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL en_on_step: got %b exp %b", got, exp); end
        mode = 1'b0; in_valid = 1'b0;
        clk_step();
        in_valid = 1'b1; in_sel = 3'd2;
        clk_step();
        checks++; got = {oh, valid, idx, stp, rerr}; exp = {6'b000100, 1'b1, 3'd0, 1'b0, 1'b0};
        if (got !== exp) begin errors++; $display("FAIL decode_after_scan: got %b exp %b", got, exp); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_range_err();
        test_scan();
        test_en_freeze();
        test_reset_mid_scan();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
